// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  // Index width that stays legal when a dimension collapses to 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after last_owner, wrapping.
import fifo_arb_pkg::*;

module rr_pick #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic [IW-1:0]      owner,
  output logic               found
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    owner = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_owner) + k) % NUM_REQ);
      if (req[cand]) begin
        owner = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            accept,
  output logic                          wt_ena,
  output logic [data_width-1:0]         data_in
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int BW = idx_width(MAX_BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] RST_OWNER = IW'(NUM_REQ - 1);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   last_owner, last_owner_nxt;
  logic [BW-1:0]   beat, beat_nxt;
  logic [IW-1:0]   pick;
  logic            pick_found;
  logic            owner_req;
  logic [data_width-1:0] owner_data;
  logic            wr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .owner      (pick),
    .found      (pick_found)
  );

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*data_width +: data_width];
      end
    end
  end

  // A write needs the owner still requesting and room in the FIFO; reset
  // suppresses it so an aborted burst never leaks a beat.
  assign wr = rstn && (state == BURST) && owner_req && !full;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= RST_OWNER;
      beat       <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat       <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_nxt       = beat;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt      = BURST;
          owner_nxt      = pick;
          last_owner_nxt = pick;
          beat_nxt       = '0;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (wr) begin
          if (beat == LAST_BEAT) state_nxt = IDLE;
          else                   beat_nxt  = beat + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    accept  = '0;
    wt_ena  = wr;
    data_in = wr ? owner_data : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        gnt[i]    = (state == BURST);
        accept[i] = wr;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter with a queue-based FIFO and grant-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 6;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic            full;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   accept;
  logic            wt_ena;
  logic [DW-1:0]   data_in;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .data_width(DW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .accept   (accept),
    .wt_ena   (wt_ena),
    .data_in  (data_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // requesters
  int unsigned pend [NR];
  logic [DW-1:0] nxt [NR];
  bit            incr [NR];

  // FIFO in the bench and the expected write stream
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            n_pop;

  // grant log taken from the DUT: owner per grant and writes per grant
  int glog[$];
  int wlog[$];
  logic [NR-1:0] prev_gnt = '0;

  // reference model: who owns the port and how many words written so far
  bit m_busy;
  int m_owner, m_last, m_beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend_any();
    for (int i = 0; i < NR; i++) if (pend[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req[i] = (pend[i] != 0);
      req_data[i*DW +: DW] = nxt[i];
    end
    full = (fq.size() >= DEPTH);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = NR - 1; m_owner = 0; m_beats = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit do_rst = 1'b0, input bit do_pop = 1'b0);
    logic [NR-1:0] e_gnt, e_acc, d_acc;
    logic          e_wt, d_wt;
    logic [DW-1:0] e_data, d_data, w, e;
    int            idx;
    rstn = !do_rst;
    drive_inputs();
    #1;
    e_gnt  = m_busy ? NR'(1 << m_owner) : '0;
    e_wt   = !do_rst && m_busy && req[m_owner] && !full;
    e_data = e_wt ? nxt[m_owner] : '0;
    e_acc  = e_wt ? NR'(1 << m_owner) : '0;
    chk("gnt", gnt, e_gnt);
    chk("wt_ena", wt_ena, e_wt);
    chk("data_in", data_in, e_data);
    chk("accept", accept, e_acc);
    if (gnt != 0 && prev_gnt == 0) begin
      idx = -1;
      for (int i = 0; i < NR; i++) if (gnt[i]) idx = i;
      glog.push_back(idx);
      wlog.push_back(0);
    end
    if (wt_ena === 1'b1 && wlog.size() > 0) wlog[wlog.size()-1]++;
    prev_gnt = gnt;
    d_wt = wt_ena; d_data = data_in; d_acc = accept;
    @(posedge clk);
    if (do_pop && fq.size() > 0) begin
      w = fq.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : ~w;
      chk("fifo_order", w, e);
      n_pop++;
    end
    if (d_wt === 1'b1 && fq.size() < DEPTH) fq.push_back(d_data);
    if (e_wt) exp_q.push_back(e_data);
    for (int i = 0; i < NR; i++) begin
      if (d_acc[i] === 1'b1 && pend[i] != 0) begin
        pend[i]--;
        if (incr[i]) nxt[i]++;
      end
    end
    if (do_rst) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = NR; k >= 1; k--) begin
        idx = (m_last + k) % NR;
        if (req[idx]) m_owner = idx;
      end
      if (req != 0) begin
        m_busy = 1'b1; m_last = m_owner; m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
    end else if (e_wt) begin
      m_beats++;
      if (m_beats == MB) m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    step(1'b1); step(1'b1);
    glog.delete(); wlog.delete();
  endtask

  task automatic drain();
    int guard = 0;
    while ((fq.size() != 0 || pend_any()) && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk("drain_bounded", guard < 200, 1);
    chk("drain_fifo_empty", fq.size(), 0);
    chk("drain_exp_empty", exp_q.size(), 0);
  endtask

  task automatic set_req(input int i, input int unsigned n, input logic [DW-1:0] d, input bit inc);
    pend[i] = n; nxt[i] = d; incr[i] = inc;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) set_req(i, 0, '0, 1'b1);
    n_pop = 0;
    rstn = 1'b0; req = '0; req_data = '0; full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_wt_ena", wt_ena, 0);
    chk("rst_accept", accept, 0);
    chk("rst_data_in", data_in, 0);

    // single requester, 6 words: 4-word burst, bubble, then 2 more
    reset_dut();
    set_req(0, 6, 8'h10, 1'b1);
    repeat (12) step();
    chk("s1_fifo_count", fq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("s1_word", (i < fq.size()) ? 32'(fq[i]) : 32'hDEAD, 32'h10 + i);
    chk("s1_grants", glog.size(), 2);
    chk("s1_grant0", (glog.size() > 0) ? glog[0] : -1, 0);
    chk("s1_burst0", (wlog.size() > 0) ? wlog[0] : -1, 4);
    chk("s1_grant1", (glog.size() > 1) ? glog[1] : -1, 0);
    chk("s1_burst1", (wlog.size() > 1) ? wlog[1] : -1, 2);
    drain();

    // all four requesting, data = index; grants rotate with 4-word bursts
    reset_dut();
    for (int i = 0; i < NR; i++) set_req(i, 8, DW'(i), 1'b0);
    repeat (45) step(1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      chk("s2_grant_order", (g < glog.size()) ? glog[g] : -1, g % NR);
      chk("s2_burst_len", (g < wlog.size()) ? wlog[g] : -1, MB);
    end
    drain();

    // requester 2 stalls on a full FIFO, then resumes
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      fq.push_back(DW'(8'hA0 + i));
      exp_q.push_back(DW'(8'hA0 + i));
    end
    n_pop = 0;
    set_req(2, 6, 8'h20, 1'b1);
    repeat (7) step();
    drive_inputs(); #1;
    chk("s3_full", full, 1);
    chk("s3_stall_gnt", gnt, 4'b0100);
    chk("s3_stall_wt", wt_ena, 0);
    step(1'b0, 1'b1);
    step();
    chk("s3_resumed_fill", fq.size(), DEPTH);
    drain();
    chk("s3_word_count", n_pop, 10);

    // requester 1 drops after 2 beats; requester 2 takes over
    reset_dut();
    set_req(1, 2, 8'h40, 1'b1);
    set_req(2, 3, 8'h50, 1'b1);
    repeat (12) step(1'b0, 1'b1);
    chk("s4_grant0", (glog.size() > 0) ? glog[0] : -1, 1);
    chk("s4_writes0", (wlog.size() > 0) ? wlog[0] : -1, 2);
    chk("s4_grant1", (glog.size() > 1) ? glog[1] : -1, 2);
    chk("s4_writes1", (wlog.size() > 1) ? wlog[1] : -1, 3);
    drain();

    // reset lands on the 3rd beat of a burst
    reset_dut();
    set_req(0, 8, 8'h60, 1'b1);
    set_req(3, 4, 8'h70, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("s5_pre_writes", (wlog.size() > 0) ? wlog[0] : -1, 2);
    chk("s5_regrant", (glog.size() > 1) ? glog[1] : -1, 0);
    drain();

    // randomized traffic, backpressure, drops and resets
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i] == 0 && $urandom_range(3, 0) == 0)
          set_req(i, $urandom_range(7, 1), DW'($urandom), 1'b1);
        else if (pend[i] != 0 && $urandom_range(40, 0) == 0)
          pend[i] = 0;
      end
      step($urandom_range(99, 0) == 0, $urandom_range(2, 0) != 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing one sync_fifo write port.
REQ-002 Parameter data_width, default 8: word width, equal to the FIFO data_width.
REQ-003 Parameter MAX_BURST, default 4: maximum words written per grant before re-arbitration.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester write request, held while data is pending.
REQ-007 req_data  input  NUM_REQ*data_width  packed data; slice i belongs to requester i.
REQ-008 full  input  1  FIFO full flag.
REQ-009 gnt  output  NUM_REQ  registered one-hot grant, or all zero.
REQ-010 accept  output  NUM_REQ  per-requester word-taken strobe; the requester advances its data on the same edge.
REQ-011 wt_ena  output  1  FIFO write enable.
REQ-012 data_in  output  data_width  FIFO write data.

Function
REQ-013 The state machine SHALL have two states: IDLE and BURST.
REQ-014 In IDLE with any req bit set, the block SHALL select the owner by round-robin, searching from last_owner+1 modulo NUM_REQ, and enter BURST on the next edge with gnt[owner]=1.
REQ-015 In IDLE with req all zero, the block SHALL remain in IDLE with gnt=0.
REQ-016 In IDLE, wt_ena SHALL be 0, giving one arbitration bubble per grant.
REQ-017 In BURST, wt_ena SHALL equal req[owner] AND NOT full, combinationally, in the same cycle.
REQ-018 data_in SHALL equal slice owner of req_data whenever wt_ena=1, and 0 otherwise.
REQ-019 accept[i] SHALL equal wt_ena AND (i==owner); at most one accept bit is set.
REQ-020 A beat counter SHALL reset to 0 on grant and increment on each cycle with wt_ena=1.
REQ-021 BURST SHALL exit to IDLE (gnt cleared on the same edge) when:
- a write occurs with beat count = MAX_BURST-1; or
- req[owner]=0, in which case no write occurs that cycle.
REQ-022 While full=1 in BURST with req[owner]=1, the block SHALL hold the grant with no write and no beat increment (stall).
REQ-023 last_owner SHALL update to owner on entry to BURST.
REQ-024 Non-owner req bits SHALL be ignored during BURST.
REQ-025 A requester that drops and reasserts req during its own burst SHALL lose the grant and re-arbitrate normally.

Reset
REQ-026 With rstn=0 at a clk edge, the block SHALL set:
- state to IDLE;
- gnt, accept, wt_ena and data_in to 0;
- beat count to 0;
- last_owner to NUM_REQ-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-burst SHALL abort the burst; no wt_ena SHALL be issued in the reset cycle.

Structure
REQ-028 A shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default parameter constants.
REQ-029 Round-robin selection SHALL live in a combinational sub-module rr_pick:
- inputs: req, last_owner;
- outputs: owner index and a found flag.
REQ-030 The top SHALL connect gnt, wt_ena and data_in to a sync_fifo instance in the bench, with the FIFO's full fed back.

Verification
REQ-031 Reset, then req=4'b0001, req_data[7:0] incrementing from 8'h10 for 6 words:
- gnt=0001 one cycle after req;
- FIFO receives 10,11,12,13 (4-word burst);
- one IDLE bubble, then re-grant of requester 0;
- FIFO then receives 14,15.
REQ-032 req=4'b1111 held, each requester sending its index as data:
- grants rotate 0,1,2,3,0;
- each grant writes exactly 4 words.
REQ-033 Fill the FIFO to full while requester 2 owns the grant:
- wt_ena=0 and gnt=0100 held while full=1;
- the write resumes on the first cycle full=0;
- no word is lost or duplicated.
REQ-034 Requester 1 drops req after 2 beats:
- exactly 2 writes occur;
- gnt clears on the next edge;
- the next grant goes to requester 2 if it is requesting.
REQ-035 Assert rstn=0 during the 3rd beat of a burst:
- wt_ena=0 in the reset cycle;
- the next grant after reset goes to requester 0.
REQ-036 Read the FIFO to empty after each scenario; data order SHALL match the grant order, with the scoreboard reporting zero mismatches.
